// File: rtl/int_frame_sum_pkg.sv
// Shared constants, state encoding and sizing helper for int_frame_sum.
// RESULT_LEN exists only when INT_FRAME_SUM_LEN_TRAILER_EN is defined.
package int_frame_sum_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MAX_WORDS  = 8;

`ifdef INT_FRAME_SUM_LEN_TRAILER_EN
  typedef enum logic [1:0] {
    ACCUM      = 2'd0,
    RESULT     = 2'd1,
    RESULT_LEN = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    RESULT = 2'd1
  } state_t;
`endif

  // Number of bits needed to represent value (1 -> 1, 7 -> 3, 8 -> 4).
  function automatic int clogb2(input int value);
    int v;
    int r;
    r = 0;
    v = value;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/int_frame_sum.sv
// AXI4-Stream frame summer: one modulo-2^DATA_WIDTH sum beat per input frame.
// Define INT_FRAME_SUM_LEN_TRAILER_EN to append a length/truncation trailer beat.
module int_frame_sum
  import int_frame_sum_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_WORDS  = DEF_MAX_WORDS
) (
  input  logic                            axi_clk,
  input  logic                            axi_reset_n,
  input  logic                            s_axis_valid,
  input  logic [DATA_WIDTH-1:0]           s_axis_data,
  input  logic                            s_axis_last,
  output logic                            s_axis_ready,
  output logic                            m_axis_valid,
  output logic [DATA_WIDTH-1:0]           m_axis_data,
  output logic                            m_axis_last,
  input  logic                            m_axis_ready,
  output logic                            frame_trunc,
  output logic [clogb2(MAX_WORDS-1):0]    beat_count
);

  localparam int            CW       = clogb2(MAX_WORDS-1) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_WORDS - 1);

  // Handshakes: a beat transfers on a rising edge where valid && ready.
  // Input and output phases never overlap: s_axis_ready is high only in ACCUM.
`ifdef INT_FRAME_SUM_LEN_TRAILER_EN
  localparam logic SUM_LAST = 1'b0;
`else
  localparam logic SUM_LAST = 1'b1;
`endif

  state_t                state;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_next;
  logic                  closing;

  assign s_axis_ready = (state == ACCUM);
  assign acc_next     = acc + s_axis_data;
  assign closing      = s_axis_last || (beat_count == LAST_IDX);

`ifdef INT_FRAME_SUM_LEN_TRAILER_EN
  logic                  trunc_flag;
  logic [DATA_WIDTH-1:0] trailer_word;

  // Trailer: zero-extended beat count with the truncation flag in the MSB.
  always_comb begin
    trailer_word                 = '0;
    trailer_word[CW-1:0]         = beat_count;
    trailer_word[DATA_WIDTH-1]   = trunc_flag;
  end
`endif

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state        <= ACCUM;
      acc          <= '0;
      beat_count   <= '0;
      m_axis_data  <= '0;
      m_axis_valid <= 1'b0;
      m_axis_last  <= 1'b0;
      frame_trunc  <= 1'b0;
`ifdef INT_FRAME_SUM_LEN_TRAILER_EN
      trunc_flag   <= 1'b0;
`endif
    end else begin
      frame_trunc <= 1'b0;
      case (state)
        ACCUM: begin
          if (s_axis_valid) begin
            acc        <= acc_next;
            beat_count <= beat_count + 1'b1;
            if (closing) begin
              m_axis_data  <= acc_next;
              m_axis_valid <= 1'b1;
              m_axis_last  <= SUM_LAST;
              frame_trunc  <= !s_axis_last;
`ifdef INT_FRAME_SUM_LEN_TRAILER_EN
              trunc_flag   <= !s_axis_last;
`endif
              state        <= RESULT;
            end
          end
        end
        RESULT: begin
          if (m_axis_ready) begin
`ifdef INT_FRAME_SUM_LEN_TRAILER_EN
            m_axis_data <= trailer_word;
            m_axis_last <= 1'b1;
            state       <= RESULT_LEN;
`else
            m_axis_valid <= 1'b0;
            m_axis_last  <= 1'b0;
            acc          <= '0;
            beat_count   <= '0;
            state        <= ACCUM;
`endif
          end
        end
`ifdef INT_FRAME_SUM_LEN_TRAILER_EN
        RESULT_LEN: begin
          if (m_axis_ready) begin
            m_axis_valid <= 1'b0;
            m_axis_last  <= 1'b0;
            acc          <= '0;
            beat_count   <= '0;
            trunc_flag   <= 1'b0;
            state        <= ACCUM;
          end
        end
`endif
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_int_frame_sum.sv
// Directed bench for int_frame_sum: frame-level sum model, per-cycle output checks
// and hand-computed literal expectations for each scenario.
module tb_int_frame_sum;

  localparam int DW = 32;
  localparam int MW = 8;
  localparam int CW = 4;

`ifdef INT_FRAME_SUM_LEN_TRAILER_EN
  localparam logic SUM_LAST = 1'b0;
`else
  localparam logic SUM_LAST = 1'b1;
`endif

  // Clock / reset
  logic          axi_clk      = 1'b0;
  logic          axi_reset_n  = 1'b0;
  logic          s_axis_valid = 1'b0;
  logic [DW-1:0] s_axis_data  = '0;
  logic          s_axis_last  = 1'b0;
  logic          s_axis_ready;
  logic          m_axis_valid;
  logic [DW-1:0] m_axis_data;
  logic          m_axis_last;
  logic          m_axis_ready = 1'b1;
  logic          frame_trunc;
  logic [CW-1:0] beat_count;

  always #5 axi_clk = ~axi_clk;

  int_frame_sum dut (
    .axi_clk      (axi_clk),
    .axi_reset_n  (axi_reset_n),
    .s_axis_valid (s_axis_valid),
    .s_axis_data  (s_axis_data),
    .s_axis_last  (s_axis_last),
    .s_axis_ready (s_axis_ready),
    .m_axis_valid (m_axis_valid),
    .m_axis_data  (m_axis_data),
    .m_axis_last  (m_axis_last),
    .m_axis_ready (m_axis_ready),
    .frame_trunc  (frame_trunc),
    .beat_count   (beat_count)
  );

  // Scoreboard state
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];
  logic [DW-1:0] model_sum = '0;
  int            model_cnt = 0;
  int            model_trunc_frames = 0;
  int            seen_trunc = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Frame model: sum words until last or MAX_WORDS beats, then queue the result beat(s).
  task automatic model_beat(input logic [DW-1:0] d, input logic l);
    logic trunc;
    model_sum = model_sum + d;
    model_cnt++;
    if (l || model_cnt == MW) begin
      trunc = !l;
      if (trunc) model_trunc_frames++;
      exp_q.push_back(model_sum);
      exp_last_q.push_back(SUM_LAST);
`ifdef INT_FRAME_SUM_LEN_TRAILER_EN
      exp_q.push_back((trunc ? 32'h8000_0000 : 32'h0) | DW'(model_cnt));
      exp_last_q.push_back(1'b1);
`endif
      model_sum = '0;
      model_cnt = 0;
    end
  endtask

  // Driver tasks: called at a falling edge, return at the falling edge after the handshake.
  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int guard;
    guard = 0;
    s_axis_valid = 1'b1;
    s_axis_data  = d;
    s_axis_last  = l;
    while (!s_axis_ready && guard < 100) begin
      @(negedge axi_clk);
      guard++;
    end
    if (guard >= 100) check("s_ready_timeout", 0, 1);
    model_beat(d, l);
    @(negedge axi_clk);
    s_axis_valid = 1'b0;
    s_axis_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!s_axis_ready && guard < 100) begin
      @(negedge axi_clk);
      guard++;
    end
    if (guard >= 100) check("idle_timeout", 0, 1);
  endtask

  // Compare process: sampled a little after the falling edge, after driver updates.
  logic          prev_vld = 1'b0;
  logic          prev_rdy = 1'b0;
  logic          prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always begin
    @(negedge axi_clk);
    #2;
    if (!axi_reset_n) begin
      prev_vld = 1'b0;
    end else begin
      check("phase_exclusive", DW'(s_axis_ready & m_axis_valid), 0);
      if (prev_vld && !prev_rdy) begin
        check("hold_valid", DW'(m_axis_valid), 1);
        check("hold_data", m_axis_data, prev_data);
        check("hold_last", DW'(m_axis_last), DW'(prev_last));
      end
      if (frame_trunc) begin
        seen_trunc++;
        check("trunc_on_valid_rise", DW'({prev_vld, m_axis_valid}), 2'b01);
      end
      if (m_axis_valid && m_axis_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else begin
          check("result_data", m_axis_data, exp_q.pop_front());
          check("result_last", DW'(m_axis_last), DW'(exp_last_q.pop_front()));
        end
      end
      prev_vld  = m_axis_valid;
      prev_rdy  = m_axis_ready;
      prev_data = m_axis_data;
      prev_last = m_axis_last;
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge axi_clk);
    check("rst_m_valid", DW'(m_axis_valid), 0);
    check("rst_m_data", m_axis_data, 0);
    check("rst_m_last", DW'(m_axis_last), 0);
    check("rst_trunc", DW'(frame_trunc), 0);
    check("rst_beat_count", DW'(beat_count), 0);
    axi_reset_n = 1'b1;
    @(negedge axi_clk);
    check("rst_s_ready", DW'(s_axis_ready), 1);

    // Full frame 1..8 with last on beat 8
    for (int i = 1; i <= 8; i++) send_beat(DW'(i), i == 8);
    check("t1_valid", DW'(m_axis_valid), 1);
    check("t1_data", m_axis_data, 32'h0000_0024);
    check("t1_last", DW'(m_axis_last), DW'(SUM_LAST));
    check("t1_trunc", DW'(frame_trunc), 0);
    check("t1_beat_count", DW'(beat_count), 8);
    wait_idle();

    // Short frame, one-cycle latency, input blocked during result
    send_beat(32'd10, 1'b0);
    send_beat(32'd20, 1'b0);
    send_beat(32'd30, 1'b1);
    check("t2_valid", DW'(m_axis_valid), 1);
    check("t2_data", m_axis_data, 32'h0000_003C);
    check("t2_s_ready", DW'(s_axis_ready), 0);
    check("t2_beat_count", DW'(beat_count), 3);
    wait_idle();

    // Modulo wrap
    send_beat(32'hFFFF_FFFF, 1'b0);
    send_beat(32'h0000_0002, 1'b1);
    check("t3_data", m_axis_data, 32'h0000_0001);
    wait_idle();

    // Truncated frame then a follow-on frame
    for (int i = 0; i < 8; i++) send_beat(32'd1, 1'b0);
    check("t4_trunc", DW'(frame_trunc), 1);
    check("t4_data", m_axis_data, 32'h0000_0008);
    check("t4_beat_count", DW'(beat_count), 8);
    wait_idle();
    send_beat(32'd5, 1'b0);
    send_beat(32'd5, 1'b1);
    check("t4b_data", m_axis_data, 32'h0000_000A);
    check("t4b_trunc", DW'(frame_trunc), 0);
    check("t4b_beat_count", DW'(beat_count), 2);
    wait_idle();
    check("t4_trunc_pulses", DW'(seen_trunc), 1);
    check("t4_trunc_model", DW'(seen_trunc), DW'(model_trunc_frames));

    // Back-pressure: result held for 6 stalled cycles
    m_axis_ready = 1'b0;
    send_beat(32'd7, 1'b0);
    send_beat(32'd9, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge axi_clk);
      check("t5_stall_s_ready", DW'(s_axis_ready), 0);
      check("t5_stall_valid", DW'(m_axis_valid), 1);
      check("t5_stall_data", m_axis_data, 32'h0000_0010);
    end
    m_axis_ready = 1'b1;
    @(negedge axi_clk);
`ifdef INT_FRAME_SUM_LEN_TRAILER_EN
    check("t5_trailer_valid", DW'(m_axis_valid), 1);
    check("t5_trailer_data", m_axis_data, 32'h0000_0002);
    check("t5_trailer_last", DW'(m_axis_last), 1);
    @(negedge axi_clk);
`endif
    check("t5_accepted_valid", DW'(m_axis_valid), 0);
    check("t5_accepted_s_ready", DW'(s_axis_ready), 1);

    // Reset mid-frame discards the partial sum
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b0);
    send_beat(32'd3, 1'b0);
    axi_reset_n = 1'b0;
    #1;
    check("t6_rst_valid", DW'(m_axis_valid), 0);
    check("t6_rst_beat_count", DW'(beat_count), 0);
    model_sum = '0;
    model_cnt = 0;
    exp_q.delete();
    exp_last_q.delete();
    @(negedge axi_clk);
    axi_reset_n = 1'b1;
    @(negedge axi_clk);
    check("t6_idle_valid", DW'(m_axis_valid), 0);
    check("t6_idle_s_ready", DW'(s_axis_ready), 1);
    send_beat(32'd4, 1'b0);
    send_beat(32'd4, 1'b1);
    check("t6_data", m_axis_data, 32'h0000_0008);
    check("t6_beat_count", DW'(beat_count), 2);
`ifdef INT_FRAME_SUM_LEN_TRAILER_EN
    @(negedge axi_clk);
    check("t6_trailer_data", m_axis_data, 32'h0000_0002);
    check("t6_trailer_last", DW'(m_axis_last), 1);
`endif
    wait_idle();
    repeat (2) @(negedge axi_clk);

    check("exp_q_drained", DW'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
